// File: rtl/updown_counter_display.sv
// Push-button up/down counter with load, wrap/saturate limits and a
// sequential double-dabble converter driving active-low seven-segment digits.
module updown_counter_display #(
    parameter int N         = 6,
    parameter int DIGITS    = 2,
    parameter int DB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  incr,
    input  logic                  decr,
    input  logic                  load,
    input  logic                  sat_mode,
    input  logic [N-1:0]          countEntr,
    output logic [N-1:0]          countSal,
    output logic                  zero,
    output logic                  full,
    output logic [7*DIGITS-1:0]   segs,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [N-1:0] MAX_COUNT = '1;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    function automatic logic [63:0] pow10(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    // Button path: index 0 = incr, index 1 = decr.
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, deb, deb_q, pulse;
    logic [CW-1:0] db_cnt [2];

    assign raw = {decr, incr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            pulse <= deb & ~deb_q;
            for (int i = 0; i < 2; i++) begin
                // A disagreeing level must persist DB_CYCLES cycles in a row.
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countSal <= '0;
        end else if (load) begin
            countSal <= countEntr;
        end else if (pulse[0] && !pulse[1]) begin
            if (countSal == MAX_COUNT) countSal <= sat_mode ? countSal : '0;
            else                       countSal <= countSal + N'(1);
        end else if (pulse[1] && !pulse[0]) begin
            if (countSal == '0) countSal <= sat_mode ? countSal : MAX_COUNT;
            else                countSal <= countSal - N'(1);
        end
    end

    assign zero = (countSal == '0);
    assign full = (countSal == MAX_COUNT);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [N-1:0]    shadow;
    logic [N-1:0]    sr;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [IW-1:0]   iter;
    logic            overflow;
    logic [7*DIGITS-1:0] seg_next;

    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < DIGITS; k++)
            bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    // Out-of-range values blank to dashes; the truncated BCD is ignored then.
    assign overflow = (64'(shadow) > LIMIT);

    always_comb begin
        seg_next = '0;
        for (int k = 0; k < DIGITS; k++)
            seg_next[7*k +: 7] = overflow ? SEG_DASH : seg7(bcd[4*k +: 4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            shadow <= '0;
            sr     <= '0;
            bcd    <= '0;
            iter   <= '0;
            segs   <= {DIGITS{SEG_ZERO}};
        end else begin
            case (state)
                IDLE: begin
                    if (countSal != shadow) begin
                        shadow <= countSal;
                        sr     <= countSal;
                        bcd    <= '0;
                        iter   <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[BW-2:0], sr[N-1]};
                    sr  <= sr << 1;
                    if (iter == IW'(N - 1)) begin
                        state <= DONE;
                    end else begin
                        iter <= iter + IW'(1);
                    end
                end
                DONE: begin
                    segs  <= seg_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_updown_counter_display.sv
// Randomised bench for updown_counter_display against an arithmetic count/display model.
module tb_updown_counter_display;

  localparam int NA = 6;
  localparam int NB = 8;
  localparam int DB = 16;
  localparam int MODA = 1 << NA;

  logic clk;
  logic rst;
  logic incr, decr, load, sat_mode;
  logic [NA-1:0] count_entr;
  logic [NA-1:0] count_sal;
  logic zero, full, busy;
  logic [13:0] segs;
  logic [1:0] dbg_state;

  logic load_b;
  logic [NB-1:0] count_entr_b;
  logic [NB-1:0] count_sal_b;
  logic zero_b, full_b, busy_b;
  logic [13:0] segs_b;
  logic [1:0] dbg_state_b;
  logic tie0;

  int tests_run;
  int tests_failed;
  int model_cnt;

  updown_counter_display #(.N(NA), .DIGITS(2), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .incr(incr), .decr(decr), .load(load),
    .sat_mode(sat_mode), .countEntr(count_entr), .countSal(count_sal),
    .zero(zero), .full(full), .segs(segs), .busy(busy), .dbg_state(dbg_state)
  );

  updown_counter_display #(.N(NB), .DIGITS(2), .DB_CYCLES(DB)) dut_b (
    .clk(clk), .rst(rst), .incr(tie0), .decr(tie0), .load(load_b),
    .sat_mode(tie0), .countEntr(count_entr_b), .countSal(count_sal_b),
    .zero(zero_b), .full(full_b), .segs(segs_b), .busy(busy_b), .dbg_state(dbg_state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [13:0] exp_segs(input int v);
    logic [6:0] pat [10];
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 99) return {7'b0111111, 7'b0111111};
    return {pat[(v / 10) % 10], pat[v % 10]};
  endfunction

  function automatic int model_next(input int c, input bit up, input bit dn, input bit sat);
    if (up && !dn) return sat ? ((c == MODA - 1) ? c : c + 1) : (c + 1) % MODA;
    if (dn && !up) return sat ? ((c == 0) ? c : c - 1) : (c + MODA - 1) % MODA;
    return c;
  endfunction

  // driver tasks
  task automatic press(input bit up, input bit dn);
    incr = up;
    decr = dn;
    tick(DB + 6);
    incr = 1'b0;
    decr = 1'b0;
    tick(DB + 6);
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    count_entr = NA'(v);
    tick(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    tests_run++;
    if (count_sal !== '0 || zero !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d zero=%0b full=%0b busy=%0b expected 0/1/0/0", count_sal, zero, full, busy);
    end
    tests_run++;
    if (segs !== exp_segs(0) || segs_b !== exp_segs(0) || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_segs: segs=%b segs_b=%b state=%0d expected %b", segs, segs_b, dbg_state, exp_segs(0));
    end
    rst = 1'b1;
    tick(100);
    tests_run++;
    if (count_sal !== '0 || segs !== exp_segs(0) || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_100: count=%0d segs=%b busy=%0b expected 0 %b 0", count_sal, segs, busy, exp_segs(0));
    end
    model_cnt = 0;
  endtask

  task automatic test_incr_timing;
    for (int p = 0; p < 3; p++) begin
      incr = 1'b1;
      tick(DB + 3);
      tests_run++;
      if (count_sal !== NA'(model_cnt)) begin
        tests_failed++;
        $display("FAIL step_early_%0d: count=%0d expected %0d", p, count_sal, model_cnt);
      end
      tick(1);
      model_cnt = model_cnt + 1;
      tests_run++;
      if (count_sal !== NA'(model_cnt)) begin
        tests_failed++;
        $display("FAIL step_edge_%0d: count=%0d expected %0d", p, count_sal, model_cnt);
      end
      tick(NA + 1);
      tests_run++;
      if (segs !== exp_segs(model_cnt - 1) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL segs_before_%0d: segs=%b busy=%0b expected %b 1", p, segs, busy, exp_segs(model_cnt - 1));
      end
      tick(1);
      tests_run++;
      if (segs !== exp_segs(model_cnt) || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL segs_update_%0d: segs=%b busy=%0b expected %b 0", p, segs, busy, exp_segs(model_cnt));
      end
      tick(2);
      incr = 1'b0;
      tick(DB + 6);
    end
  endtask

  task automatic test_bounce;
    incr = 1'b1;
    for (int i = 0; i < 40; i += 3) begin
      tick(3);
      incr = ~incr;
    end
    incr = 1'b1;
    tick(30);
    incr = 1'b0;
    tick(DB + 6);
    model_cnt = model_next(model_cnt, 1'b1, 1'b0, sat_mode);
    tests_run++;
    if (count_sal !== NA'(model_cnt)) begin
      tests_failed++;
      $display("FAIL bounce: count=%0d expected %0d", count_sal, model_cnt);
    end
  endtask

  task automatic test_limits;
    sat_mode = 1'b0;
    do_load(MODA - 1);
    tests_run++;
    if (count_sal !== NA'(MODA - 1) || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_max: count=%0d full=%0b expected %0d 1", count_sal, full, MODA - 1);
    end
    press(1'b1, 1'b0);
    tests_run++;
    if (count_sal !== '0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_up: count=%0d zero=%0b expected 0 1", count_sal, zero);
    end
    sat_mode = 1'b1;
    do_load(MODA - 1);
    press(1'b1, 1'b0);
    tests_run++;
    if (count_sal !== NA'(MODA - 1) || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_up: count=%0d full=%0b expected %0d 1", count_sal, full, MODA - 1);
    end
    do_load(0);
    press(1'b0, 1'b1);
    tests_run++;
    if (count_sal !== '0) begin
      tests_failed++;
      $display("FAIL sat_down: count=%0d expected 0", count_sal);
    end
    sat_mode = 1'b0;
    press(1'b0, 1'b1);
    tick(NA + 4);
    tests_run++;
    if (count_sal !== NA'(MODA - 1) || segs !== exp_segs(MODA - 1)) begin
      tests_failed++;
      $display("FAIL wrap_down: count=%0d segs=%b expected %0d %b", count_sal, segs, MODA - 1, exp_segs(MODA - 1));
    end
    model_cnt = MODA - 1;
  endtask

  task automatic test_priority;
    do_load(10);
    incr = 1'b1;
    tick(DB + 1);
    load = 1'b1;
    count_entr = NA'(25);
    tick(4);
    load = 1'b0;
    tick(5);
    incr = 1'b0;
    tick(DB + 6);
    tests_run++;
    if (count_sal !== NA'(25)) begin
      tests_failed++;
      $display("FAIL load_over_step: count=%0d expected 25", count_sal);
    end
    press(1'b1, 1'b1);
    tests_run++;
    if (count_sal !== NA'(25)) begin
      tests_failed++;
      $display("FAIL both_pulses: count=%0d expected 25", count_sal);
    end
    model_cnt = 25;
  endtask

  task automatic test_random;
    int op, v;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      sat_mode = 1'($urandom_range(0, 1));
      case (op)
        0: begin press(1'b1, 1'b0); model_cnt = model_next(model_cnt, 1'b1, 1'b0, sat_mode); end
        1: begin press(1'b0, 1'b1); model_cnt = model_next(model_cnt, 1'b0, 1'b1, sat_mode); end
        2: begin press(1'b1, 1'b1); model_cnt = model_next(model_cnt, 1'b1, 1'b1, sat_mode); end
        default: begin v = $urandom_range(0, MODA - 1); do_load(v); model_cnt = v; end
      endcase
      tests_run++;
      if (count_sal !== NA'(model_cnt) || zero !== (model_cnt == 0) || full !== (model_cnt == MODA - 1)) begin
        tests_failed++;
        $display("FAIL random_count_%0d: count=%0d zero=%0b full=%0b expected %0d", it, count_sal, zero, full, model_cnt);
      end
      tick(NA + 4);
      tests_run++;
      if (segs !== exp_segs(model_cnt) || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_segs_%0d: segs=%b busy=%0b expected %b 0", it, segs, busy, exp_segs(model_cnt));
      end
    end
  endtask

  task automatic test_reset_held;
    do_load(45);
    tick(3);
    rst = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || count_sal !== '0 || segs !== exp_segs(0)) begin
      tests_failed++;
      $display("FAIL reset_abort: busy=%0b count=%0d segs=%b expected 0 0 %b", busy, count_sal, segs, exp_segs(0));
    end
    tick(2);
    rst = 1'b1;
    tick(2);
    incr = 1'b1;
    tick(DB + 6);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(DB + 3);
    tests_run++;
    if (count_sal !== '0) begin
      tests_failed++;
      $display("FAIL held_no_pulse: count=%0d expected 0", count_sal);
    end
    tick(1);
    tests_run++;
    if (count_sal !== NA'(1)) begin
      tests_failed++;
      $display("FAIL held_redebounce: count=%0d expected 1", count_sal);
    end
    incr = 1'b0;
    tick(DB + 6);
    model_cnt = 1;
  endtask

  task automatic test_overflow;
    int changes;
    logic [13:0] prev;
    load_b = 1'b1;
    count_entr_b = NB'(200);
    tick(1);
    load_b = 1'b0;
    tick(NB + 4);
    tests_run++;
    if (segs_b !== exp_segs(200)) begin
      tests_failed++;
      $display("FAIL overflow_dash: segs=%b expected %b", segs_b, exp_segs(200));
    end
    load_b = 1'b1;
    count_entr_b = NB'(37);
    tick(1);
    load_b = 1'b0;
    tick(3);
    load_b = 1'b1;
    count_entr_b = NB'(58);
    tick(1);
    load_b = 1'b0;
    tick(2 * (NB + 3));
    tests_run++;
    if (segs_b !== exp_segs(58) || busy_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL converge: segs=%b busy=%0b expected %b 0", segs_b, busy_b, exp_segs(58));
    end
    changes = 0;
    prev = segs_b;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (segs_b !== prev) changes++;
      prev = segs_b;
    end
    tests_run++;
    if (changes != 0) begin
      tests_failed++;
      $display("FAIL stable_after_final: changes=%0d expected 0", changes);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    model_cnt = 0;
    tie0 = 1'b0;
    rst = 1'b0;
    incr = 1'b0;
    decr = 1'b0;
    load = 1'b0;
    sat_mode = 1'b0;
    count_entr = '0;
    load_b = 1'b0;
    count_entr_b = '0;
    test_reset;
    test_incr_timing;
    test_bounce;
    test_limits;
    test_priority;
    test_random;
    test_reset_held;
    test_overflow;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
